// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RD_LAT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_mport_wordline_decoder.sv
// One-hot wordline decoder for an arbitrary depth; IDs past the end select nothing.
module wordline_decoder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic [AW-1:0]    id,
  input  logic             en,
  output logic [DEPTH-1:0] wl
);

  always_comb begin
    wl = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wl[i] = en && (id == AW'(i));
    end
  end

endmodule

// File: rtl/regfile_mport.sv
// Register file with one write port, NR registered read ports (write-first) and a clear engine.
// Optional macro REG0_ZERO_EN turns register 0 into a hardwired zero register.
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int NR    = 2,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_id,
  input  logic [W-1:0]   wr_data,
  input  logic [NR-1:0]  rd_en,
  input  logic [NR*AW-1:0] rd_id,
  output logic [NR*W-1:0]  rd_data,
  output logic [NR-1:0]  rd_valid,
  input  logic           clr_req,
  output logic           busy
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NR*W-1:0]  rd_data_q, rd_data_d;
  logic [NR-1:0]    rd_valid_q, rd_valid_d;
  logic [DEPTH-1:0] wr_wl;
  logic [DEPTH-1:0] upd_wl;
  logic [W-1:0]     upd_data;
  logic [DEPTH-1:0] rd_wl [NR];
  logic             idle;

  assign idle = (state_q == IDLE);

  wordline_decoder #(.DEPTH(DEPTH), .AW(AW)) u_wr_dec (
    .id (wr_id),
    .en (wr_en & idle),
    .wl (wr_wl)
  );

  for (genvar p = 0; p < NR; p++) begin : g_rd_dec
    wordline_decoder #(.DEPTH(DEPTH), .AW(AW)) u_rd_dec (
      .id (rd_id[p*AW +: AW]),
      .en (rd_en[p]),
      .wl (rd_wl[p])
    );
  end

  // The array has a single update source per cycle: the write port in IDLE, the clear row in CLEAR.
  always_comb begin
    upd_wl   = '0;
    upd_data = '0;
    if (idle) begin
      upd_wl   = wr_wl;
      upd_data = wr_data;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        upd_wl[i] = (cnt_q == AW'(i));
      end
    end
`ifdef REG0_ZERO_EN
    upd_wl[0] = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = upd_wl[i] ? upd_data : mem_q[i];
    end
  end

  // Reading the post-update array gives write-first bypass and zero for the row being cleared.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    for (int p = 0; p < NR; p++) begin
      if (rd_en[p]) begin
        rd_data_d[p*W +: W] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_wl[p][i]) rd_data_d[p*W +: W] = mem_d[i];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mport.sv
// Scoreboard bench: two instances (DEPTH 16 and 12) driven by identical stimulus, checked against an array model.
module tb_regfile_mport;

  localparam int W  = 32;
  localparam int NR = 2;
  localparam int AW = 4;
`ifdef REG0_ZERO_EN
  localparam bit ZERO0 = 1'b1;
`else
  localparam bit ZERO0 = 1'b0;
`endif

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [AW-1:0] wr_id;
  logic [W-1:0] wr_data;
  logic [NR-1:0] rd_en;
  logic [NR*AW-1:0] rd_id;
  logic clr_req;
  logic [NR*W-1:0] rd_data16, rd_data12;
  logic [NR-1:0] rd_valid16, rd_valid12;
  logic busy16, busy12;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] regs [2][16];
  bit          mbusy [2];
  int          mcnt [2];
  exp_t        q16[$];
  exp_t        q12[$];

  always #5 clk = ~clk;

  regfile_mport #(.W(W), .DEPTH(16), .NR(NR)) dut16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data16), .rd_valid(rd_valid16),
    .clr_req(clr_req), .busy(busy16)
  );

  regfile_mport #(.W(W), .DEPTH(12), .NR(NR)) dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data12), .rd_valid(rd_valid12),
    .clr_req(clr_req), .busy(busy12)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) regs[d][i] = '0;
      mbusy[d] = 1'b0;
      mcnt[d]  = 0;
    end
    q16.delete();
    q12.delete();
  endtask

  // Apply the current inputs to the model for the coming edge and queue read expectations.
  task automatic model_step();
    int dp;
    int id;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      dp = (d == 0) ? 16 : 12;
      if (!mbusy[d]) begin
        if (wr_en && int'(wr_id) < dp && !(ZERO0 && wr_id == 4'd0)) regs[d][wr_id] = wr_data;
      end else begin
        regs[d][mcnt[d]] = 32'd0;
      end
      for (int p = 0; p < NR; p++) begin
        if (rd_en[p]) begin
          id     = int'(rd_id[p*AW +: AW]);
          e.port = p;
          e.data = (id < dp) ? regs[d][id] : 32'd0;
          if (d == 0) q16.push_back(e);
          else        q12.push_back(e);
        end
      end
      if (!mbusy[d]) begin
        if (clr_req) begin
          mbusy[d] = 1'b1;
          mcnt[d]  = 0;
        end
      end else if (mcnt[d] == dp - 1) begin
        mbusy[d] = 1'b0;
        mcnt[d]  = 0;
      end else begin
        mcnt[d]++;
      end
    end
  endtask

  task automatic cycle(input logic we, input logic [3:0] wid, input logic [31:0] wd,
                       input logic [1:0] re, input logic [3:0] i0, input logic [3:0] i1,
                       input logic clr);
    wr_en   = we;
    wr_id   = wid;
    wr_data = wd;
    rd_en   = re;
    rd_id   = {i1, i0};
    clr_req = clr;
    model_step();
    @(posedge clk);
    #1;
    chk("busy16", 32'(busy16), 32'(mbusy[0]));
    chk("busy12", 32'(busy12), 32'(mbusy[1]));
    wr_en   = 1'b0;
    rd_en   = 2'b00;
    clr_req = 1'b0;
  endtask

  task automatic readall();
    for (int i = 0; i < 16; i += 2) cycle(1'b0, 4'd0, 32'd0, 2'b11, 4'(i), 4'(i + 1), 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 1'b0);
  endtask

  // Monitor: every presented read result must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int p = 0; p < NR; p++) begin
        if (rd_valid16[p]) begin
          if (q16.size() == 0) begin
            n_chk++;
            $display("FAIL rd16_spurious: port %0d valid with no expectation", p);
          end else begin
            e = q16.pop_front();
            chk("rd16_port", 32'(p), 32'(e.port));
            chk("rd16_data", rd_data16[p*W +: W], e.data);
          end
        end
        if (rd_valid12[p]) begin
          if (q12.size() == 0) begin
            n_chk++;
            $display("FAIL rd12_spurious: port %0d valid with no expectation", p);
          end else begin
            e = q12.pop_front();
            chk("rd12_port", 32'(p), 32'(e.port));
            chk("rd12_data", rd_data12[p*W +: W], e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb16, nb12;
    rst = 1'b1; wr_en = 1'b0; wr_id = '0; wr_data = '0; rd_en = '0; rd_id = '0; clr_req = 1'b0;
    model_reset();
    #12;
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_valid16", 32'(rd_valid16), 32'd0);
    chk("rst_data16_p0", rd_data16[31:0], 32'd0);
    chk("rst_data12_p1", rd_data12[63:32], 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Write then read on port 1.
    cycle(1'b1, 4'd5, 32'hDEADBEEF, 2'b00, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 2'b10, 4'd0, 4'd5, 1'b0);
    chk("t1_data", rd_data16[63:32], 32'hDEADBEEF);
    chk("t1_valid", 32'(rd_valid16), 32'h2);

    // Same-edge write with both ports reading it.
    cycle(1'b1, 4'd9, 32'h0000_1234, 2'b11, 4'd9, 4'd9, 1'b0);
    chk("t2_data0", rd_data16[31:0], 32'h0000_1234);
    chk("t2_data1", rd_data16[63:32], 32'h0000_1234);
    chk("t2_valid", 32'(rd_valid16), 32'h3);

    // Out-of-range ID on the 12-deep instance.
    cycle(1'b1, 4'd13, 32'hA5A5_0013, 2'b00, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 2'b11, 4'd13, 4'd13, 1'b0);
    chk("t4_data12", rd_data12[31:0], 32'd0);
    chk("t4_valid12", 32'(rd_valid12), 32'h3);
    chk("t4_data16", rd_data16[31:0], 32'hA5A5_0013);
    readall();

    // Register 0 with same-edge read.
    cycle(1'b1, 4'd0, 32'hFFFF_FFFF, 2'b01, 4'd0, 4'd0, 1'b0);
    chk("t6_reg0", rd_data16[31:0], ZERO0 ? 32'd0 : 32'hFFFF_FFFF);

    // Fill, clear, writes during clear are dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom, 2'b00, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 1'b1);
    nb16 = int'(busy16);
    nb12 = int'(busy12);
    for (int k = 0; k < 19; k++) begin
      cycle(k < 15, 4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      nb16 += int'(busy16);
      nb12 += int'(busy12);
    end
    chk("t3_busy_len16", 32'(nb16), 32'd16);
    chk("t3_busy_len12", 32'(nb12), 32'd12);
    readall();

    // Asynchronous reset with the clear counter at 7.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), $urandom | 32'h1, 2'b00, 4'd0, 4'd0, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b0, 4'd0, 32'd0, 2'b11, 4'd15, 4'd14, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy16", 32'(busy16), 32'd0);
    chk("t5_busy12", 32'(busy12), 32'd0);
    chk("t5_data16_p0", rd_data16[31:0], 32'd0);
    chk("t5_data16_p1", rd_data16[63:32], 32'd0);
    chk("t5_valid16", 32'(rd_valid16), 32'd0);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    readall();

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 49) == 0);
    end
    for (int k = 0; k < 20; k++) cycle(1'b0, 4'd0, 32'd0, 2'b00, 4'd0, 4'd0, 1'b0);
    readall();

    @(negedge clk);
    #1;
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q12_drained", 32'(q12.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
